// File: rtl/seq_divider_32by16.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
// Produces one quotient bit per clock and uses valid/ready handshakes on both sides.
// Define DIVIDER_ABORT_EN at build time to add the abort input, which cancels an
// operation that is still in CHECK or RUN.
module seq_divider_32by16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
`ifdef DIVIDER_ABORT_EN
  ,
  input  logic               abort
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCheck, StRun, StDone} state_e;

  state_e             r_state;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_rem;      // partial remainder, always < divisor between steps
  logic [WIDTH-1:0]   r_qsh;      // dividend low half shifting out, quotient shifting in
  logic [CntW-1:0]    r_cnt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_dbz;
  logic               r_ovf;

  logic               w_abort;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_qsh_next;
  logic               w_last;

`ifdef DIVIDER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // One restoring step: trial value needs WIDTH+1 bits since the shifted-out MSB of r_rem
  // can be set; the difference still fits WIDTH bits because r_rem < divisor.
  assign w_trial    = {r_rem, r_qsh[WIDTH-1]};
  assign w_diff     = w_trial - {1'b0, r_divisor};
  assign w_ge       = (w_trial >= {1'b0, r_divisor});
  assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_qsh_next = {r_qsh[WIDTH-2:0], w_ge};
  assign w_last     = (r_cnt == CntW'(WIDTH - 1));

  assign in_ready    = (r_state == StIdle);
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

  // Control FSM, working registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_qsh       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_divisor <= divisor;
            r_rem     <= dividend[2*WIDTH-1:WIDTH];
            r_qsh     <= dividend[WIDTH-1:0];
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
            r_state   <= StCheck;
          end
        end
        StCheck: begin
          if (w_abort) begin
            r_state <= StIdle;
          end else if (r_divisor == '0) begin
            r_dbz       <= 1'b1;
            r_quotient  <= '1;
            r_remainder <= r_qsh;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else if (r_rem >= r_divisor) begin
            // High half >= divisor means the quotient needs more than WIDTH bits.
            r_ovf       <= 1'b1;
            r_quotient  <= '1;
            r_remainder <= r_qsh;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_cnt   <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (w_abort) begin
            r_state <= StIdle;
          end else begin
            r_rem <= w_rem_next;
            r_qsh <= w_qsh_next;
            r_cnt <= r_cnt + CntW'(1);
            if (w_last) begin
              r_quotient  <= w_qsh_next;
              r_remainder <= w_rem_next;
              r_out_valid <= 1'b1;
              r_state     <= StDone;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32by16.sv
// Directed bench for seq_divider_32by16 with a scoreboard of expected results.
// Build with DIVIDER_ABORT_EN defined to also exercise the abort input.
module tb_seq_divider_32by16;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;
`ifdef DIVIDER_ABORT_EN
  logic        abort = 1'b0;
`endif

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t last_exp = '0;

  always #5 clk = ~clk;

  seq_divider_32by16 #(.WIDTH(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
`ifdef DIVIDER_ABORT_EN
    .overflow   (overflow),
    .abort      (abort)
`else
    .overflow   (overflow)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] dd, input logic [15:0] dv);
    exp_t e;
    logic [31:0] dv32;
    dv32 = {16'h0, dv};
    e = '0;
    if (dv == 16'h0) begin
      e.dbz = 1'b1;
      e.q   = 16'hFFFF;
      e.r   = dd[15:0];
    end else if (dd[31:16] >= dv) begin
      e.ovf = 1'b1;
      e.q   = 16'hFFFF;
      e.r   = dd[15:0];
    end else begin
      e.q = 16'(dd / dv32);
      e.r = 16'(dd % dv32);
    end
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, "_quotient"}, 32'(quotient), 32'(e.q));
    check({tag, "_remainder"}, 32'(remainder), 32'(e.r));
    check({tag, "_flags"}, {30'h0, div_by_zero, overflow}, {30'h0, e.dbz, e.ovf});
  endtask

  // Present one operation and push its expected result once it is accepted.
  task automatic start_op(input logic [31:0] dd, input logic [15:0] dv);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_before_op", 32'(in_ready), 32'd1);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sb.push_back(model(dd, dv));
  endtask

  // Wait for out_valid, check latency in edges after the accept edge, then score the result.
  task automatic wait_result(input string tag);
    int   lat = 0;
    int   exp_lat;
    exp_t e;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      exp_lat = (e.dbz || e.ovf) ? 1 : 17;
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check_outputs(tag, e);
      check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      last_exp = e;
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_cleared"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] dd, input logic [15:0] dv);
    start_op(dd, dv);
    wait_result(tag);
    consume(tag);
  endtask

  initial begin
    exp_t e;
    int   seen;
    logic [31:0] a, b, r;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check_outputs("reset", '0);

    // Directed cases
    run_op("exact", 32'h0626_0060, 16'h5678);
    run_op("with_rem", 32'h0626_0065, 16'h5678);
    run_op("div_zero", 32'h0000_ABCD, 16'h0000);
    run_op("overflow", 32'h5678_0000, 16'h5678);
    run_op("max_exact", 32'hFFFE_0001, 16'hFFFF);
    run_op("hi_eq_lim", 32'hFFFF_FFFF, 16'hFFFF);
    run_op("small", 32'h0000_0007, 16'h0003);

    // Back-pressure: result held, busy input ignored
    start_op(32'h0626_0065, 16'h5678);
    wait_result("hold");
    e = last_exp;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1);
      dividend = 32'h0000_0010;
      divisor  = 16'h0002;
      tick();
      in_valid = 1'b0;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check_outputs("hold", e);
    end
    consume("hold");
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("hold_no_ghost_op", 32'(seen), 32'd0);

    // Random exact-fit operations
    for (int i = 0; i < 6; i++) begin
      a = 32'($urandom_range(0, 32'hFFFF));
      b = 32'($urandom_range(1, 32'hFFFF));
      r = 32'($urandom_range(0, b - 1));
      run_op("random", a * b + r, b[15:0]);
    end

`ifdef DIVIDER_ABORT_EN
    // Abort at RUN iteration 8: no result, outputs keep previous values
    e = last_exp;
    start_op(32'h0626_0060, 16'h5678);
    void'(sb.pop_back());
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check_outputs("abort", e);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
`endif

    // Reset at RUN iteration 8 discards the operation and clears outputs
    start_op(32'h0626_0065, 16'h5678);
    void'(sb.pop_back());
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check_outputs("midrst", '0);
    run_op("after_rst", 32'h0626_0060, 16'h5678);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
